poly_pair_mul_seq: RTL and testbench
====================================

// Module: poly_pair_mul_seq
// PURPOSE
// - Sequential, parametrised "product of all operands but one" engine: captures N_IN unsigned
//   W-bit operands and a select code, then outputs the product of every operand except the
//   selected one (sel=0 -> 0).
// - For N_IN=3, W=16 it computes in2*in3 / in1*in3 / in1*in2 for sel=1/2/3 into a 32-bit result.
// - Sits between an operand source and a result consumer, with valid/ready on both sides.
// - Uses one W x P multiply step per cycle instead of a wide combinational product tree.
// PARAMETERS
// - N_IN   3   number of operands, >=2
// - W      16  operand width in bits, >=1
// - SEL_W  $clog2(N_IN+1)  select width (derived localparam, not overridable)
// - P      W*(N_IN-1)      result width (derived localparam)
// PORTS
// - clk        in   1         rising-edge clock, single domain
// - rst_n      in   1         asynchronous active-low reset
// - in_valid   in   1         operand set and sel valid
// - in_ready   out  1         block can accept an operand set
// - in_ops     in   N_IN*W    operand k (1-based) at bits [(k-1)*W +: W]
// - in_sel     in   SEL_W     0 = zero result; k in 1..N_IN = exclude operand k
// - out_valid  out  1         result valid
// - out_ready  in   1         consumer accepts result
// - out_data   out  P         result
// - out_err    out  1         qualifies out_data: in_sel was > N_IN
// - busy       out  1         high in RUN or DONE
// BEHAVIOUR
// - Reset (async assert, sync deassert by the system): state=IDLE, in_ready=1, out_valid=0,
//   out_data=0, out_err=0, busy=0, idx=0, acc=0.
// - FSM IDLE -> RUN -> DONE -> IDLE. in_ready=1 only in IDLE.
// - Accept: in_valid & in_ready at an edge -> capture in_ops and in_sel into registers; acc<=1;
//   idx<=0; go to RUN. Later changes on inputs have no effect.
// - RUN, one step per cycle: acc <= (acc * f)[P-1:0]
//   - f = 1 if idx == sel-1, else op[idx]
//   - idx <= idx+1; the step with idx==N_IN-1 moves to DONE and loads out_data.
//   - The true product of N_IN-1 W-bit values fits in P bits, so truncation never loses bits.
// - sel=0: out_data=0, out_err=0. sel>N_IN: out_data=0, out_err=1. Latency is the same as any valid sel.
// - Latency fixed: out_valid rises exactly N_IN cycles after the accepting edge.
// - Throughput: one operation per N_IN+2 cycles (accept, N_IN RUN, >=1 DONE).
// - DONE: out_valid=1; out_data and out_err are held stable until out_valid & out_ready at an
//   edge, then IDLE with out_valid=0. out_data keeps its last value after the handshake.
// - Backpressure: out_ready may stay low indefinitely. No new accept happens while in DONE.
// - Simultaneous events: in_valid is ignored outside IDLE, without overwrite or queueing.
// - out_ready is ignored when out_valid=0.
// - Reset mid-operation (RUN or DONE): abort immediately and return to reset values.
//   The in-flight result is discarded and never presented.
// - Multiplier: unsigned, W x P -> P bits, combinational within one cycle.
//   No multicycle paths are assumed.
// TESTING (N_IN=3, W=16 unless noted)
// - ops {3,5,7}, sel=1/2/3/0 back-to-back, out_ready=1
//   -> out_data = 35 / 21 / 15 / 0, each exactly 3 cycles after accept, out_err=0.
// - ops {0xFFFF,0xFFFF,0x1234}, sel=3 -> out_data=0xFFFE0001 (no truncation).
// - N_IN=4, W=8: ops {2,3,4,5}, sel=1 -> 60 after 4 cycles.
//   Same set with sel=6 -> out_data=0, out_err=1.
// - Backpressure: hold out_ready=0 for 10 cycles after out_valid
//   -> out_data stable, in_ready=0, a new in_valid is not accepted.
//   Release -> one handshake, then IDLE.
// - Change in_ops on the cycle after accept -> result still matches the captured operands.
// - Assert rst_n=0 mid-RUN -> all outputs reach reset values immediately.
//   After release, accepting {3,5,7}, sel=2 -> 21 with normal latency.

Source files
------------

// File: rtl/poly_pair_mul_seq_if.sv
// Operand/result handshake bundle for poly_pair_mul_seq: operand set + select in,
// product + error flag out, valid/ready on each side.
interface poly_pair_mul_seq_if #(
  parameter int N_IN = 3,
  parameter int W    = 16
);
  localparam int SEL_W = $clog2(N_IN + 1);
  localparam int P     = W * (N_IN - 1);

  logic              in_valid;
  logic              in_ready;
  logic [N_IN*W-1:0] in_ops;
  logic [SEL_W-1:0]  in_sel;
  logic              out_valid;
  logic              out_ready;
  logic [P-1:0]      out_data;
  logic              out_err;

  modport master (
    output in_valid, in_ops, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_ops, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/poly_pair_mul_seq.sv
// Product of all captured operands except the selected one, one W x P multiply per cycle.
// out_valid rises N_IN cycles after accept; result held in DONE until out_ready, no accept meanwhile.
module poly_pair_mul_seq #(
  parameter int N_IN = 3,
  parameter int W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  poly_pair_mul_seq_if.slave  bus,
  output logic                busy
);
  localparam int SEL_W = $clog2(N_IN + 1);
  localparam int P     = W * (N_IN - 1);
  localparam int IDX_W = $clog2(N_IN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [N_IN*W-1:0] ops_q;
  logic [SEL_W-1:0]  sel_q;
  logic [IDX_W-1:0]  idx_q;
  logic [P-1:0]      acc_q;
  logic [P-1:0]      data_q;
  logic              err_q;

  logic [W-1:0]      op_cur;
  logic [W-1:0]      factor;
  logic [P-1:0]      prod;
  logic              last_step;
  logic              sel_ok;
  logic              sel_err;

  always_comb begin
    op_cur    = ops_q[idx_q*W +: W];
    // The excluded operand contributes a factor of one, keeping the step count fixed.
    factor    = ((sel_q != '0) && (32'(sel_q) == 32'(idx_q) + 32'd1)) ? W'(1) : op_cur;
    prod      = acc_q * P'(factor);
    last_step = (idx_q == IDX_W'(N_IN - 1));
    sel_err   = (32'(sel_q) > N_IN);
    sel_ok    = (sel_q != '0) && !sel_err;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ops_q   <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            ops_q <= bus.in_ops;
            sel_q <= bus.in_sel;
            acc_q <= P'(1);
            idx_q <= '0;
          end
        end
        RUN: begin
          acc_q <= prod;
          idx_q <= idx_q + 1'b1;
          if (last_step) begin
            data_q <= sel_ok ? prod : '0;
            err_q  <= sel_err;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = data_q;
  assign bus.out_err   = err_q;
  assign busy          = (state_q == RUN) || (state_q == DONE);
endmodule

// File: tb/tb_poly_pair_mul_seq.sv
// Directed bench for poly_pair_mul_seq at N_IN=3/W=16 and N_IN=4/W=8.
module tb_poly_pair_mul_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy3, busy4;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  poly_pair_mul_seq_if #(.N_IN(3), .W(16)) b3 ();
  poly_pair_mul_seq_if #(.N_IN(4), .W(8))  b4 ();

  poly_pair_mul_seq #(.N_IN(3), .W(16)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3), .busy(busy3));
  poly_pair_mul_seq #(.N_IN(4), .W(8))  dut4 (.clk(clk), .rst_n(rst_n), .bus(b4), .busy(busy4));

  typedef struct {
    logic [47:0] ops;
    logic [1:0]  sel;
    logic [31:0] data;
    logic        err;
  } vec3_t;

  typedef struct {
    logic [31:0] ops;
    logic [2:0]  sel;
    logic [23:0] data;
    logic        err;
  } vec4_t;

  vec3_t v3[6];
  vec4_t v4[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Accept one operand set, scramble the inputs right after, wait for out_valid.
  task automatic op3(input logic [47:0] ops, input logic [1:0] sel,
                     output logic [31:0] data, output logic err, output int lat);
    int n;
    @(negedge clk);
    b3.in_ops = ops; b3.in_sel = sel; b3.in_valid = 1'b1;
    n = 0;
    while (!b3.in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    b3.in_valid = 1'b0; b3.in_ops = ~ops; b3.in_sel = sel + 2'd1;
    lat = 0;
    while (!b3.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!b3.out_valid) lat = 99;
    data = b3.out_data; err = b3.out_err;
  endtask

  task automatic op4(input logic [31:0] ops, input logic [2:0] sel,
                     output logic [23:0] data, output logic err, output int lat);
    int n;
    @(negedge clk);
    b4.in_ops = ops; b4.in_sel = sel; b4.in_valid = 1'b1;
    n = 0;
    while (!b4.in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    b4.in_valid = 1'b0; b4.in_ops = ~ops; b4.in_sel = sel + 3'd1;
    lat = 0;
    while (!b4.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!b4.out_valid) lat = 99;
    data = b4.out_data; err = b4.out_err;
  endtask

  initial begin
    logic [31:0] d3;
    logic [23:0] d4;
    logic        e;
    int          lat;
    int          seen;

    v3[0] = '{48'h0007_0005_0003, 2'd1, 32'd35, 1'b0};
    v3[1] = '{48'h0007_0005_0003, 2'd2, 32'd21, 1'b0};
    v3[2] = '{48'h0007_0005_0003, 2'd3, 32'd15, 1'b0};
    v3[3] = '{48'h0007_0005_0003, 2'd0, 32'd0,  1'b0};
    v3[4] = '{48'h1234_FFFF_FFFF, 2'd3, 32'hFFFE_0001, 1'b0};
    v3[5] = '{48'h1234_FFFF_FFFF, 2'd1, 32'h1233_EDCC, 1'b0};

    v4[0] = '{32'h0504_0302, 3'd1, 24'd60, 1'b0};
    v4[1] = '{32'h0504_0302, 3'd6, 24'd0,  1'b1};
    v4[2] = '{32'h0504_0302, 3'd4, 24'd24, 1'b0};
    v4[3] = '{32'h0504_0302, 3'd0, 24'd0,  1'b0};

    b3.in_valid = 1'b0; b3.in_ops = '0; b3.in_sel = '0; b3.out_ready = 1'b1;
    b4.in_valid = 1'b0; b4.in_ops = '0; b4.in_sel = '0; b4.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  b3.in_ready,  1'b1);
    chk("rst_out_valid", b3.out_valid, 1'b0);
    chk("rst_out_data",  b3.out_data,  32'd0);
    chk("rst_out_err",   b3.out_err,   1'b0);
    chk("rst_busy",      busy3,        1'b0);

    foreach (v3[i]) begin
      op3(v3[i].ops, v3[i].sel, d3, e, lat);
      chk($sformatf("v3_%0d_data", i), d3, v3[i].data);
      chk($sformatf("v3_%0d_err", i),  e,  v3[i].err);
      chk($sformatf("v3_%0d_lat", i),  lat, 3);
    end

    foreach (v4[i]) begin
      op4(v4[i].ops, v4[i].sel, d4, e, lat);
      chk($sformatf("v4_%0d_data", i), d4, v4[i].data);
      chk($sformatf("v4_%0d_err", i),  e,  v4[i].err);
      chk($sformatf("v4_%0d_lat", i),  lat, 4);
    end

    // Backpressure: result held while a competing operand set is offered.
    @(negedge clk);
    b3.out_ready = 1'b0;
    op3(48'h0007_0005_0003, 2'd1, d3, e, lat);
    chk("bp_first_data", d3, 32'd35);
    b3.in_ops = 48'h0002_0002_0002; b3.in_sel = 2'd2; b3.in_valid = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (b3.out_data !== 32'd35 || b3.in_ready !== 1'b0 || b3.out_valid !== 1'b1) seen++;
    end
    chk("bp_hold_violations", seen, 0);
    @(negedge clk);
    b3.in_valid = 1'b0; b3.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", b3.out_valid, 1'b0);
    chk("bp_release_ready", b3.in_ready,  1'b1);
    chk("bp_data_kept",     b3.out_data,  32'd35);
    repeat (2) @(posedge clk); #1;
    chk("bp_no_accept_busy", busy3, 1'b0);

    // Reset while in RUN aborts the operation.
    @(negedge clk);
    b3.in_ops = 48'h0007_0005_0003; b3.in_sel = 2'd3; b3.in_valid = 1'b1;
    @(posedge clk); #1;
    b3.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_run_busy", busy3, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",      busy3,        1'b0);
    chk("abort_in_ready",  b3.in_ready,  1'b1);
    chk("abort_out_valid", b3.out_valid, 1'b0);
    chk("abort_out_data",  b3.out_data,  32'd0);
    chk("abort_out_err",   b3.out_err,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (b3.out_valid) seen++;
    end
    chk("abort_never_presented", seen, 0);
    op3(48'h0007_0005_0003, 2'd2, d3, e, lat);
    chk("post_rst_data", d3, 32'd21);
    chk("post_rst_lat",  lat, 3);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
